// File: rtl/hdlverifier_jtag_pkg.sv
// Shared constants for the JTAG responder: data width, register word
// addresses and CTRL register bit positions.
package hdlverifier_jtag_pkg;

  localparam int DATA_W        = 32;
  localparam int SCRATCH_WORDS = 16;

  localparam logic [4:0] ADDR_ID           = 5'd0;
  localparam logic [4:0] ADDR_CTRL         = 5'd1;
  localparam logic [4:0] ADDR_STATUS       = 5'd2;
  localparam logic [4:0] ADDR_UNDERFLOW    = 5'd3;
  localparam logic [4:0] ADDR_OVERFLOW     = 5'd4;
  localparam logic [4:0] ADDR_USER_CTRL    = 5'd5;
  localparam logic [4:0] ADDR_SCRATCH_BASE = 5'd16;

  // CTRL is write-only and self-clearing; these are strobe bit positions.
  localparam int CTRL_CLR_CNT = 0;
  localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/hdlverifier_jtag_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_flush          empties the FIFO; wins over a same-cycle push/pop
//   i_push, i_data   write request and word
//   i_pop            read request (ignored when empty)
//   o_head           word at the head of the FIFO (valid when !o_empty)
//   o_level          number of stored words
//   o_full, o_empty  status flags
module hdlverifier_jtag_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is accepted only when a pop frees a slot.
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok && i_rst_n && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/hdlverifier_jtag_responder.sv
// Fabric-side responder to the JTAG command core (tck domain).
// Ports:
//   tck, reset_n                 clock, synchronous active-low reset
//   reg_addr/wdata/write/rdata   register file access from the core
//   shift_out_state/en/data      serialiser of capture-FIFO words (LSB first)
//   shift_in_state/en/data       deserialiser of host bits (LSB first)
//   s_tdata/tvalid/tready        capture stream into the FIFO
//   m_tdata/tvalid/tready        host-written words out to fabric
//   user_ctrl                    contents of register 5
module hdlverifier_jtag_responder
  import hdlverifier_jtag_pkg::*;
#(
  parameter int                FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] ID_VALUE   = 32'h4A54_4147
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic [4:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_write,
  output logic [DATA_W-1:0] reg_rdata,
  input  logic              shift_out_state,
  input  logic              shift_out_en,
  output logic              shift_out_data,
  input  logic              shift_in_state,
  input  logic              shift_in_en,
  input  logic              shift_in_data,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] user_ctrl
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] r_scratch [SCRATCH_WORDS];
  logic [DATA_W-1:0] r_user_ctrl, r_underflow, r_overflow, r_rdata;
  logic [DATA_W-1:0] r_in_acc, r_hold;
  logic              r_hold_vld, r_out_state_q, r_in_state_q, r_rdy;
  logic [4:0]        r_bit_idx, r_in_idx;

  logic [DATA_W-1:0] w_head, w_in_word, w_rdata_next;
  logic [LVL_W-1:0]  w_level;
  logic              w_full, w_empty;
  logic              w_wr_ctrl, w_clr_cnt, w_flush, w_push, w_pop, w_underflow;
  logic              w_out_adv, w_out_wrap, w_out_fall;
  logic              w_in_adv, w_in_done, w_in_fall, w_overflow, w_accept;

  assign w_wr_ctrl = reg_write && (reg_addr == ADDR_CTRL);
  assign w_clr_cnt = w_wr_ctrl && reg_wdata[CTRL_CLR_CNT];
  assign w_flush   = w_wr_ctrl && reg_wdata[CTRL_FLUSH];

  // Capture path: a pop happens at the end of a word or when a transfer
  // ends part-way through one; an end-of-word on an empty FIFO is an underflow.
  assign w_push      = s_tvalid && s_tready;
  assign w_out_adv   = shift_out_state && shift_out_en;
  assign w_out_wrap  = w_out_adv && (r_bit_idx == 5'd31);
  assign w_out_fall  = r_out_state_q && !shift_out_state && (r_bit_idx != 5'd0);
  assign w_pop       = (w_out_wrap || w_out_fall) && !w_empty;
  assign w_underflow = w_out_wrap && w_empty;

  // Write path: the word completes on the 32nd accepted bit.
  assign w_in_adv   = shift_in_state && shift_in_en;
  assign w_in_done  = w_in_adv && (r_in_idx == 5'd31);
  assign w_in_fall  = r_in_state_q && !shift_in_state && (r_in_idx != 5'd0);
  assign w_in_word  = {shift_in_data, r_in_acc[DATA_W-1:1]};
  assign w_accept   = r_hold_vld && m_tready;
  assign w_overflow = w_in_done && r_hold_vld && !m_tready;

  assign shift_out_data = w_empty ? 1'b0 : w_head[r_bit_idx];
  assign s_tready       = r_rdy && !w_full;
  assign m_tdata        = r_hold;
  assign m_tvalid       = r_hold_vld;
  assign user_ctrl      = r_user_ctrl;
  assign reg_rdata      = r_rdata;

  hdlverifier_jtag_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (tck),
    .i_rst_n (reset_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (s_tdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rdata_next = '0;
    case (reg_addr)
      ADDR_ID:        w_rdata_next = ID_VALUE;
      ADDR_STATUS:    w_rdata_next = {14'd0, w_full, r_hold_vld, 7'd0, 9'(w_level)};
      ADDR_UNDERFLOW: w_rdata_next = r_underflow;
      ADDR_OVERFLOW:  w_rdata_next = r_overflow;
      ADDR_USER_CTRL: w_rdata_next = r_user_ctrl;
      default: begin
        if (reg_addr >= ADDR_SCRATCH_BASE) w_rdata_next = r_scratch[reg_addr[3:0]];
      end
    endcase
  end

  always_ff @(posedge tck) begin
    if (!reset_n) begin
      for (int i = 0; i < SCRATCH_WORDS; i++) r_scratch[i] <= '0;
      r_user_ctrl   <= '0;
      r_underflow   <= '0;
      r_overflow    <= '0;
      r_rdata       <= '0;
      r_in_acc      <= '0;
      r_hold        <= '0;
      r_hold_vld    <= 1'b0;
      r_out_state_q <= 1'b0;
      r_in_state_q  <= 1'b0;
      r_rdy         <= 1'b0;
      r_bit_idx     <= '0;
      r_in_idx      <= '0;
    end else begin
      r_rdy         <= 1'b1;
      r_rdata       <= w_rdata_next;
      r_out_state_q <= shift_out_state;
      r_in_state_q  <= shift_in_state;

      if (reg_write) begin
        if (reg_addr == ADDR_USER_CTRL) r_user_ctrl <= reg_wdata;
        else if (reg_addr >= ADDR_SCRATCH_BASE) r_scratch[reg_addr[3:0]] <= reg_wdata;
      end

      if (w_clr_cnt) r_underflow <= '0;
      else if (w_underflow && (r_underflow != '1)) r_underflow <= r_underflow + 32'd1;

      if (w_clr_cnt) r_overflow <= '0;
      else if (w_overflow && (r_overflow != '1)) r_overflow <= r_overflow + 32'd1;

      if (w_out_fall) r_bit_idx <= '0;
      else if (w_out_adv) r_bit_idx <= r_bit_idx + 5'd1;

      if (w_in_fall) r_in_idx <= '0;
      else if (w_in_adv) r_in_idx <= r_in_idx + 5'd1;
      if (w_in_adv) r_in_acc <= w_in_word;

      // A completing word may replace the held one only if it is being
      // accepted this cycle; otherwise the new word is the one dropped.
      if (w_flush) begin
        r_hold_vld <= 1'b0;
      end else if (w_in_done && (!r_hold_vld || m_tready)) begin
        r_hold     <= w_in_word;
        r_hold_vld <= 1'b1;
      end else if (w_accept) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdlverifier_jtag_responder.sv
module tb_hdlverifier_jtag_responder;

  logic        tck = 1'b0;
  logic        reset_n;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic [31:0] reg_rdata;
  logic        shift_out_state, shift_out_en, shift_out_data;
  logic        shift_in_state, shift_in_en, shift_in_data;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready;
  logic [31:0] user_ctrl;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ID = 32'h4A54_4147;

  always #5 tck = ~tck;

  hdlverifier_jtag_responder dut (
    .tck(tck), .reset_n(reset_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_rdata(reg_rdata),
    .shift_out_state(shift_out_state), .shift_out_en(shift_out_en), .shift_out_data(shift_out_data),
    .shift_in_state(shift_in_state), .shift_in_en(shift_in_en), .shift_in_data(shift_in_data),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .user_ctrl(user_ctrl)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_uc;
  } reg_vec_t;

  reg_vec_t vecs [18];

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    reg_addr = a;
    reg_write = 1'b0;
    tick();
    d = reg_rdata;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    reg_addr = a;
    reg_wdata = d;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic shift_word(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      shift_in_en = 1'b1;
      shift_in_data = d[i];
      tick();
    end
    shift_in_en = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    s_tdata = d;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] stream;
    logic        acc;

    vecs[0]  = '{1'b0, 5'd0,  32'h0,         ID,            32'h0};
    vecs[1]  = '{1'b0, 5'd6,  32'h0,         32'h0,         32'h0};
    vecs[2]  = '{1'b0, 5'd15, 32'h0,         32'h0,         32'h0};
    vecs[3]  = '{1'b1, 5'd20, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 5'd20, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1'b1, 5'd5,  32'h0000_1234, 32'h0,         32'h0000_1234};
    vecs[6]  = '{1'b0, 5'd5,  32'h0,         32'h0000_1234, 32'h0000_1234};
    vecs[7]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, ID,            32'h0000_1234};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         ID,            32'h0000_1234};
    vecs[9]  = '{1'b1, 5'd6,  32'h0000_0055, 32'h0,         32'h0000_1234};
    vecs[10] = '{1'b0, 5'd6,  32'h0,         32'h0,         32'h0000_1234};
    vecs[11] = '{1'b1, 5'd1,  32'h0,         32'h0,         32'h0000_1234};
    vecs[12] = '{1'b0, 5'd1,  32'h0,         32'h0,         32'h0000_1234};
    vecs[13] = '{1'b0, 5'd2,  32'h0,         32'h0,         32'h0000_1234};
    vecs[14] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 32'h0,         32'h0000_1234};
    vecs[15] = '{1'b0, 5'd31, 32'h0,         32'hA5A5_A5A5, 32'h0000_1234};
    vecs[16] = '{1'b0, 5'd16, 32'h0,         32'h0,         32'h0000_1234};
    vecs[17] = '{1'b0, 5'd3,  32'h0,         32'h0,         32'h0000_1234};

    reset_n = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_write = 1'b0;
    shift_out_state = 1'b0; shift_out_en = 1'b0;
    shift_in_state = 1'b0; shift_in_en = 1'b0; shift_in_data = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_user_ctrl", user_ctrl, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("s_tready_after_rst", {31'd0, s_tready}, 32'd1);

    // Register file vectors
    for (int i = 0; i < 18; i++) begin
      reg_addr = vecs[i].addr;
      reg_wdata = vecs[i].wdata;
      reg_write = vecs[i].we;
      tick();
      chk($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_user_ctrl", i), user_ctrl, vecs[i].exp_uc);
    end
    reg_write = 1'b0;

    // Serialise two captured words
    push_word(32'h0000_00A5);
    push_word(32'h8000_0001);
    read_reg(5'd2, rd); chk("level_2", rd, 32'd2);
    stream = {32'h8000_0001, 32'h0000_00A5};
    shift_out_state = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) begin
        shift_out_en = 1'b0;
        read_reg(5'd2, rd); chk("level_1", rd, 32'd1);
      end
      shift_out_en = 1'b1;
      chk($sformatf("sout_bit%0d", i), {31'd0, shift_out_data}, {31'd0, stream[i]});
      tick();
    end
    shift_out_en = 1'b0;
    read_reg(5'd2, rd); chk("level_0", rd, 32'd0);
    read_reg(5'd3, rd); chk("underflow_0", rd, 32'd0);

    // Empty FIFO: one underflow per 32 shifts, data constantly 0
    acc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      shift_out_en = 1'b1;
      acc = acc | shift_out_data;
      tick();
    end
    shift_out_en = 1'b0;
    chk("empty_sout_zero", {31'd0, acc}, 32'd0);
    read_reg(5'd3, rd); chk("underflow_1", rd, 32'd1);

    // Partial word discarded when the read transfer ends early
    push_word(32'hFFFF_FFFF);
    acc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      shift_out_en = 1'b1;
      acc = acc & shift_out_data;
      tick();
    end
    shift_out_en = 1'b0;
    chk("partial_bits_one", {31'd0, acc}, 32'd1);
    shift_out_state = 1'b0;
    tick();
    read_reg(5'd2, rd); chk("partial_popped", rd, 32'd0);
    push_word(32'h0000_0002);
    shift_out_state = 1'b1;
    chk("bit_idx_restart_b0", {31'd0, shift_out_data}, 32'd0);
    shift_out_en = 1'b1;
    tick();
    shift_out_en = 1'b0;
    chk("bit_idx_restart_b1", {31'd0, shift_out_data}, 32'd1);
    shift_out_state = 1'b0;
    tick();
    read_reg(5'd2, rd); chk("partial2_popped", rd, 32'd0);
    read_reg(5'd3, rd); chk("underflow_still_1", rd, 32'd1);

    // Deserialise, overflow, accept
    m_tready = 1'b0;
    shift_in_state = 1'b1;
    shift_word(32'h1234_5678, 32);
    chk("m_tvalid_set", {31'd0, m_tvalid}, 32'd1);
    chk("m_tdata_w1", m_tdata, 32'h1234_5678);
    shift_word(32'hCAFE_F00D, 32);
    chk("m_tdata_kept", m_tdata, 32'h1234_5678);
    read_reg(5'd4, rd); chk("overflow_1", rd, 32'd1);
    read_reg(5'd2, rd); chk("status_mvalid", rd, 32'h0001_0000);
    m_tready = 1'b1;
    tick();
    chk("m_tvalid_clr", {31'd0, m_tvalid}, 32'd0);

    // Word completes in the same cycle the held word is accepted
    m_tready = 1'b0;
    shift_word(32'h1111_1111, 32);
    shift_word(32'h2222_2222, 31);
    m_tready = 1'b1;
    shift_in_en = 1'b1;
    shift_in_data = 1'b0;
    tick();
    shift_in_en = 1'b0;
    chk("accept_load_valid", {31'd0, m_tvalid}, 32'd1);
    chk("accept_load_data", m_tdata, 32'h2222_2222);
    tick();
    chk("accept_second", {31'd0, m_tvalid}, 32'd0);
    m_tready = 1'b0;
    read_reg(5'd4, rd); chk("overflow_still_1", rd, 32'd1);

    // Partial shift-in discarded
    shift_word(32'h0000_03FF, 10);
    shift_in_state = 1'b0;
    tick();
    shift_in_state = 1'b1;
    shift_word(32'h0000_0003, 32);
    chk("partial_in_discard", m_tdata, 32'h0000_0003);

    // Counter clear
    write_reg(5'd1, 32'h1);
    read_reg(5'd3, rd); chk("clr_underflow", rd, 32'd0);
    read_reg(5'd4, rd); chk("clr_overflow", rd, 32'd0);

    // Fill to full, then flush
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = i;
      tick();
    end
    s_tvalid = 1'b0;
    chk("full_s_tready", {31'd0, s_tready}, 32'd0);
    read_reg(5'd2, rd); chk("status_full", rd, 32'h0003_0010);
    write_reg(5'd1, 32'h2);
    read_reg(5'd2, rd); chk("status_flushed", rd, 32'd0);
    chk("flush_s_tready", {31'd0, s_tready}, 32'd1);

    // Reset mid-transfer
    write_reg(5'd5, 32'h0000_ABCD);
    shift_word(32'h0, 32);
    shift_word(32'h0, 32);
    read_reg(5'd4, rd); chk("pre_rst_overflow", rd, 32'd1);
    push_word(32'hFFFF_FFFF);
    shift_out_state = 1'b1;
    shift_out_en = 1'b1;
    tick(); tick(); tick();
    shift_out_en = 1'b0;
    shift_word(32'h0000_03FF, 10);
    reg_addr = 5'd5;
    reset_n = 1'b0;
    tick(); tick();
    chk("mid_rst_rdata", reg_rdata, 32'd0);
    chk("mid_rst_user_ctrl", user_ctrl, 32'd0);
    chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mid_rst_m_tdata", m_tdata, 32'd0);
    chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("mid_rst_sout", {31'd0, shift_out_data}, 32'd0);
    shift_out_state = 1'b0;
    shift_in_state = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("post_rst_s_tready", {31'd0, s_tready}, 32'd1);
    read_reg(5'd2, rd);  chk("post_rst_status", rd, 32'd0);
    read_reg(5'd4, rd);  chk("post_rst_overflow", rd, 32'd0);
    read_reg(5'd20, rd); chk("post_rst_scratch", rd, 32'd0);
    shift_in_state = 1'b1;
    shift_word(32'h0000_000A, 32);
    chk("post_rst_word", m_tdata, 32'h0000_000A);
    shift_in_state = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
